// File: rtl/instr_fetch_unit_if.sv
// Byte-FIFO read side and instruction-stream handshake of the fetch unit.
// The master modport is the fetch unit. The slave modport is the environment:
// the rx FIFO, the decode FSM and the flush source.
interface instr_fetch_unit_if #(
    parameter int FIFO_DATA_WIDTH  = 8,
    parameter int BUFFER_WORD_SIZE = 16,
    parameter int ADDRESS_SIZE     = 10
);
    logic                        flush;
    logic                        fifo_empty;
    logic                        fifo_re;
    logic [FIFO_DATA_WIDTH-1:0]  fifo_rdata;
    logic [BUFFER_WORD_SIZE-1:0] instr;
    logic [ADDRESS_SIZE-1:0]     addr;
    logic                        has_addr;
    logic                        valid;
    logic                        ready;
    logic                        frame_err;

    modport master (
        input  flush, fifo_empty, fifo_rdata, ready,
        output fifo_re, instr, addr, has_addr, valid, frame_err
    );

    modport slave (
        output flush, fifo_empty, fifo_rdata, ready,
        input  fifo_re, instr, addr, has_addr, valid, frame_err
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the uTPU controller.
// It pops bytes from the UART rx FIFO and assembles them into little-endian
// 16-bit instruction words. A flagged STORE also fetches the address word
// that follows it. Each result is offered to the decoder over valid/ready.
// A starvation timeout in the middle of a frame restores byte framing.
module instr_fetch_unit #(
    parameter int                      FIFO_DATA_WIDTH  = 8,
    parameter int                      BUFFER_WORD_SIZE = 16,
    parameter int                      ADDRESS_SIZE     = 10,
    parameter int                      OPCODE_WIDTH     = 3,
    parameter logic [OPCODE_WIDTH-1:0] STORE_OPCODE     = '0,
    parameter int                      ADDR_FLAG_BIT    = 4,
    parameter int                      TIMEOUT_CYCLES   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // The count value during the last tolerated empty cycle
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    localparam logic [3:0] I0_RD  = 4'd0;
    localparam logic [3:0] I0_CAP = 4'd1;
    localparam logic [3:0] I1_RD  = 4'd2;
    localparam logic [3:0] I1_CAP = 4'd3;
    localparam logic [3:0] A0_RD  = 4'd4;
    localparam logic [3:0] A0_CAP = 4'd5;
    localparam logic [3:0] A1_RD  = 4'd6;
    localparam logic [3:0] A1_CAP = 4'd7;
    localparam logic [3:0] OUT    = 4'd8;

    logic [3:0]                  state;
    logic [CNT_W-1:0]            cnt;
    logic [BUFFER_WORD_SIZE-1:0] instr_word;
    logic [FIFO_DATA_WIDTH-1:0]  addr_lo;
    logic [ADDRESS_SIZE-1:0]     addr_word;
    logic                        has_addr_flag;
    logic                        valid_flag;
    logic                        frame_err_flag;

    logic                        rd_state;
    logic                        wait_state;
    logic                        pop;
    logic                        timeout_hit;
    logic [BUFFER_WORD_SIZE-1:0] instr_full;
    logic                        needs_addr;

    // Pop decision, timeout detection and address-word decision for the current cycle
    always_comb begin
        rd_state    = (state == I0_RD) || (state == I1_RD) || (state == A0_RD) || (state == A1_RD);
        wait_state  = (state == I1_RD) || (state == A0_RD) || (state == A1_RD);
        // A pop during flush or reset would lose the byte, so these gate the pop.
        pop         = rd_state && !bus.fifo_empty && !bus.flush && !rst;
        timeout_hit = (TIMEOUT_CYCLES != 0) && wait_state && bus.fifo_empty && (cnt == CNT_LAST);
        instr_full  = {bus.fifo_rdata, instr_word[FIFO_DATA_WIDTH-1:0]};
        needs_addr  = (instr_full[OPCODE_WIDTH-1:0] == STORE_OPCODE) && instr_full[ADDR_FLAG_BIT];
    end

    assign bus.fifo_re   = pop;
    assign bus.instr     = instr_word;
    assign bus.addr      = addr_word;
    assign bus.has_addr  = has_addr_flag;
    assign bus.valid     = valid_flag;
    assign bus.frame_err = frame_err_flag;

    // Frame assembly FSM with starvation counter.
    // frame_err rises in the cycle after the last tolerated empty cycle,
    // which is when the counter would reach TIMEOUT_CYCLES.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= I0_RD;
            cnt            <= '0;
            instr_word     <= '0;
            addr_lo        <= '0;
            addr_word      <= '0;
            has_addr_flag  <= 1'b0;
            valid_flag     <= 1'b0;
            frame_err_flag <= 1'b0;
        end else begin
            frame_err_flag <= timeout_hit;
            if (bus.flush || timeout_hit) begin
                state         <= I0_RD;
                cnt           <= '0;
                instr_word    <= '0;
                addr_lo       <= '0;
                addr_word     <= '0;
                has_addr_flag <= 1'b0;
                valid_flag    <= 1'b0;
            end else begin
                if (pop)
                    cnt <= '0;
                else if (wait_state && bus.fifo_empty)
                    cnt <= cnt + CNT_W'(1);

                case (state)
                    I0_RD:  if (pop) state <= I0_CAP;
                    I0_CAP: begin
                        instr_word[FIFO_DATA_WIDTH-1:0] <= bus.fifo_rdata;
                        state <= I1_RD;
                    end
                    I1_RD:  if (pop) state <= I1_CAP;
                    I1_CAP: begin
                        instr_word    <= instr_full;
                        addr_lo       <= '0;
                        addr_word     <= '0;
                        has_addr_flag <= 1'b0;
                        if (needs_addr) begin
                            state <= A0_RD;
                        end else begin
                            valid_flag <= 1'b1;
                            state      <= OUT;
                        end
                    end
                    A0_RD:  if (pop) state <= A0_CAP;
                    A0_CAP: begin
                        addr_lo <= bus.fifo_rdata;
                        state   <= A1_RD;
                    end
                    A1_RD:  if (pop) state <= A1_CAP;
                    A1_CAP: begin
                        addr_word     <= ADDRESS_SIZE'({bus.fifo_rdata, addr_lo});
                        has_addr_flag <= 1'b1;
                        valid_flag    <= 1'b1;
                        state         <= OUT;
                    end
                    OUT: begin
                        if (bus.ready) begin
                            valid_flag <= 1'b0;
                            cnt        <= '0;
                            state      <= I0_RD;
                        end
                    end
                    default: state <= I0_RD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a byte-queue FIFO model,
// hand-computed instruction/address words, latency, pop counts and timeout timing.
module tb_instr_fetch_unit;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.FIFO_DATA_WIDTH(8), .BUFFER_WORD_SIZE(16), .ADDRESS_SIZE(10)) bus();

    instr_fetch_unit #(
        .FIFO_DATA_WIDTH(8), .BUFFER_WORD_SIZE(16), .ADDRESS_SIZE(10),
        .OPCODE_WIDTH(3), .STORE_OPCODE(3'd0), .ADDR_FLAG_BIT(4), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0] q[$];
    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int npop = 0;
    int first_re = -1;
    int bad_re = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: see the pop request mid-cycle, then deliver the byte just after the edge
    task automatic tick();
        logic pend;
        @(negedge clk);
        pend = bus.fifo_re;
        if (pend && bus.fifo_empty) bad_re++;
        if (pend) begin
            npop++;
            if (first_re < 0) first_re = cyc;
        end
        @(posedge clk);
        #1;
        if (pend && q.size() > 0) bus.fifo_rdata = q.pop_front();
        bus.fifo_empty = (q.size() == 0);
        cyc++;
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        bus.fifo_empty = 1'b0;
    endtask

    task automatic start_frame();
        first_re = -1;
        npop = 0;
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n = 0;
        while (bus.valid !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(bus.valid), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time 0x%0h expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int nfe;
        int fe_cyc;
        int vbad;

        rst = 1'b1;
        bus.flush = 1'b0;
        bus.ready = 1'b1;
        bus.fifo_empty = 1'b1;
        bus.fifo_rdata = 8'h00;
        repeat (3) tick();
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_instr", 32'(bus.instr), 32'd0);
        check("rst_addr", 32'(bus.addr), 32'd0);
        check("rst_has_addr", 32'(bus.has_addr), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        check("rst_fifo_re", 32'(bus.fifo_re), 32'd0);
        rst = 1'b0;
        tick();

        // Plain two-byte instruction
        start_frame();
        push(8'h12); push(8'h34);
        wait_valid("t1", 30);
        check("t1_lat", 32'(cyc - first_re), 32'd4);
        check("t1_instr", 32'(bus.instr), 32'h3412);
        check("t1_has_addr", 32'(bus.has_addr), 32'd0);
        check("t1_addr", 32'(bus.addr), 32'd0);
        check("t1_pops", 32'(npop), 32'd2);
        tick();
        check("t1_valid_drop", 32'(bus.valid), 32'd0);

        // STORE with address flag: address word follows
        start_frame();
        push(8'h10); push(8'h00); push(8'hFF); push(8'h07);
        wait_valid("t2", 30);
        check("t2_lat", 32'(cyc - first_re), 32'd8);
        check("t2_instr", 32'(bus.instr), 32'h0010);
        check("t2_has_addr", 32'(bus.has_addr), 32'd1);
        check("t2_addr", 32'(bus.addr), 32'h3FF);
        check("t2_pops", 32'(npop), 32'd4);
        tick();

        // STORE without flag: next bytes form the next instruction
        start_frame();
        push(8'h00); push(8'h00); push(8'h65); push(8'h87);
        wait_valid("t3", 30);
        check("t3_lat", 32'(cyc - first_re), 32'd4);
        check("t3_instr", 32'(bus.instr), 32'h0000);
        check("t3_has_addr", 32'(bus.has_addr), 32'd0);
        check("t3_pops", 32'(npop), 32'd2);
        tick();
        wait_valid("t3b", 30);
        check("t3b_instr", 32'(bus.instr), 32'h8765);
        check("t3b_pops", 32'(npop), 32'd4);
        tick();

        // Backpressure: hold for 20 cycles with FIFO non-empty
        bus.ready = 1'b0;
        start_frame();
        push(8'hAB); push(8'hCD); push(8'h11); push(8'h22);
        wait_valid("t4", 30);
        check("t4_instr", 32'(bus.instr), 32'hCDAB);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.valid !== 1'b1 || bus.instr !== 16'hCDAB || bus.has_addr !== 1'b0 || bus.fifo_re !== 1'b0)
                bad++;
        end
        check("t4_hold", 32'(bad), 32'd0);
        check("t4_pops_held", 32'(npop), 32'd2);
        bus.ready = 1'b1;
        tick();
        check("t4_release", 32'(bus.valid), 32'd0);
        wait_valid("t4b", 30);
        check("t4b_instr", 32'(bus.instr), 32'h2211);
        check("t4b_pops", 32'(npop), 32'd4);
        tick();

        // Starvation after one byte: timeout pulse, then a clean frame
        start_frame();
        push(8'h05);
        nfe = 0;
        fe_cyc = -1;
        vbad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.frame_err === 1'b1) begin
                nfe++;
                if (fe_cyc < 0) fe_cyc = cyc;
            end
            if (bus.valid !== 1'b0) vbad++;
        end
        check("t5_pulses", 32'(nfe), 32'd1);
        check("t5_pulse_cycle", 32'(fe_cyc - first_re), 32'd18);
        check("t5_no_valid", 32'(vbad), 32'd0);
        check("t5_pops", 32'(npop), 32'd1);
        start_frame();
        push(8'h21); push(8'h43);
        wait_valid("t5b", 30);
        check("t5b_lat", 32'(cyc - first_re), 32'd4);
        check("t5b_instr", 32'(bus.instr), 32'h4321);
        tick();

        // Flush while in A0_CAP drops the popped byte
        start_frame();
        push(8'h10); push(8'h00); push(8'hAA); push(8'hBB);
        repeat (5) tick();
        check("t6a_pops_pre", 32'(npop), 32'd3);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("t6a_valid", 32'(bus.valid), 32'd0);
        check("t6a_instr", 32'(bus.instr), 32'd0);
        check("t6a_addr", 32'(bus.addr), 32'd0);
        check("t6a_has_addr", 32'(bus.has_addr), 32'd0);
        push(8'h44);
        wait_valid("t6a_next", 30);
        check("t6a_next_instr", 32'(bus.instr), 32'h44BB);
        check("t6a_next_has_addr", 32'(bus.has_addr), 32'd0);
        check("t6a_pops", 32'(npop), 32'd5);
        tick();

        // Reset while in I1_CAP
        start_frame();
        push(8'h99); push(8'h88); push(8'h66); push(8'h77);
        repeat (3) tick();
        check("t6b_pops_pre", 32'(npop), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6b_valid", 32'(bus.valid), 32'd0);
        check("t6b_instr", 32'(bus.instr), 32'd0);
        check("t6b_addr", 32'(bus.addr), 32'd0);
        check("t6b_has_addr", 32'(bus.has_addr), 32'd0);
        check("t6b_frame_err", 32'(bus.frame_err), 32'd0);
        wait_valid("t6b_next", 30);
        check("t6b_next_instr", 32'(bus.instr), 32'h7766);
        check("t6b_pops", 32'(npop), 32'd4);
        tick();

        check("re_while_empty", 32'(bad_re), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
